// File: rtl/pe_feeder_pkg.sv
// -----------------------------------------------------------------------------
// pe_feeder_pkg
// Shared definitions for the pe_dot_feeder operand sequencer.
//   state_t    : sequencer states (WARM, IDLE, RUN, DRAIN, DONE)
//   PE_LAT     : cycles between issuing a pair and seeing it in the PE output
//   LAT_CNT_W  : width of the counter that times WARM and DRAIN
//   LAT_LAST   : terminal value of that counter
//   LAT_ONE    : increment constant sized to the counter
// -----------------------------------------------------------------------------
package pe_feeder_pkg;

  localparam int PE_LAT    = 3;
  localparam int LAT_CNT_W = $clog2(PE_LAT);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(PE_LAT - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_ONE  = LAT_CNT_W'(1);

  typedef enum logic [2:0] {
    WARM,   // post-reset settle time, operands held at zero
    IDLE,   // waiting for a job start
    RUN,    // issuing pairs from the operand FIFO
    DRAIN,  // waiting for the last pair to reach the PE output
    DONE    // result presented, waiting for the consumer
  } state_t;

endpackage

// File: rtl/operand_fifo.sv
// -----------------------------------------------------------------------------
// operand_fifo
// Synchronous FIFO holding {activation, weight} pairs for the sequencer.
// Pointers carry one extra wrap bit so that equal indices can be told apart
// as either empty (same wrap) or full (opposite wrap).
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high flush
//   push     in   write wr_data (ignored when full)
//   wr_data  in   WIDTH-bit entry
//   pop      in   advance the head (ignored when empty)
//   rd_data  out  head entry, valid whenever empty is low
//   full     out  no free entry
//   empty    out  no stored entry
// -----------------------------------------------------------------------------
module operand_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: clocked state is updated with non-blocking assignments so every
  // register samples the values from before the edge, independent of the
  // order in which the simulator runs the always_ff blocks.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers already
  // makes every entry unreachable, and a reset-free array maps onto plain
  // RAM/register-file cells instead of individually resettable flops.
  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/pe_dot_feeder.sv
// -----------------------------------------------------------------------------
// pe_dot_feeder
// Operand sequencer for one MAC processing element. Buffers incoming
// activation/weight pairs, issues a job's worth of them to the PE one per
// cycle (zeros whenever nothing is issued), and returns the job's dot product
// as the PE output after the job minus the PE output before it, so the PE
// accumulator never has to be cleared.
//
// Ports
//   i_clock         in   rising-edge clock
//   i_reset         in   synchronous active-high reset
//   i_start         in   job start, honoured only in IDLE
//   i_len           in   pairs in the job, sampled with i_start
//   i_valid         in   operand pair offered
//   i_activation    in   activation operand
//   i_weight        in   weight operand
//   o_ready         out  operand FIFO has room (low during reset)
//   o_activation    out  registered activation to the PE
//   o_weight        out  registered weight to the PE
//   i_pe_output     in   PE accumulator value
//   o_result        out  dot product of the last completed job
//   o_result_valid  out  result held until i_result_ready
//   i_result_ready  in   consumer accepts the result
//   o_busy          out  high in every state but IDLE
// -----------------------------------------------------------------------------
module pe_dot_feeder
  import pe_feeder_pkg::*;
#(
  parameter int BW    = 8,
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_valid,
  input  logic [BW-1:0]     i_activation,
  input  logic [BW-1:0]     i_weight,
  output logic              o_ready,
  output logic [BW-1:0]     o_activation,
  output logic [BW-1:0]     o_weight,
  input  logic [2*BW-1:0]   i_pe_output,
  output logic [2*BW-1:0]   o_result,
  output logic              o_result_valid,
  input  logic              i_result_ready,
  output logic              o_busy
);

  localparam int RW = 2 * BW;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t               state;
  state_t               state_next;

  logic [LEN_W-1:0]     remaining;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 lat_done;
  logic [RW-1:0]        base;

  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [2*BW-1:0]      fifo_rd_data;
  logic [BW-1:0]        fifo_activation;
  logic [BW-1:0]        fifo_weight;

  logic                 start_job;
  logic                 last_issue;

  // ---------------------------------------------------------------------------
  // Operand buffer
  // ---------------------------------------------------------------------------
  operand_fifo #(
    .WIDTH (2 * BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (i_clock),
    .reset   (i_reset),
    .push    (push),
    .wr_data ({i_activation, i_weight}),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {fifo_activation, fifo_weight} = fifo_rd_data;

  // Shared timer for WARM and DRAIN: both last PE_LAT cycles.
  assign lat_done   = (lat_cnt == LAT_LAST);
  assign start_job  = (state == IDLE) && i_start;
  // The pop that hands out the final pair of the job.
  assign last_issue = pop && (remaining == LEN_ONE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= WARM;
    else         state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets its default before the case so that every path
  // through this block assigns it; a missed path would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      WARM:  if (lat_done) state_next = IDLE;
      IDLE: begin
        if (i_start) state_next = (i_len == '0) ? DONE : RUN;
      end
      RUN:   if (last_issue) state_next = DRAIN;
      DRAIN: if (lat_done) state_next = DONE;
      DONE:  if (i_result_ready) state_next = IDLE;
      default: state_next = WARM;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and FIFO handshake
  // ---------------------------------------------------------------------------
  // o_ready is held low while reset is asserted so nothing is accepted into a
  // FIFO that is being flushed; otherwise it only reflects fullness.
  always_comb begin
    o_ready        = !fifo_full && !i_reset;
    push           = i_valid && !fifo_full && !i_reset;
    pop            = (state == RUN) && !fifo_empty;
    o_busy         = (state != IDLE);
    o_result_valid = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // WARM / DRAIN timer
  // ---------------------------------------------------------------------------
  // Counts 0..PE_LAT-1 while waiting and rests at zero otherwise, so it is
  // already cleared when RUN hands over to DRAIN.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      lat_cnt <= '0;
    end else if ((state == WARM || state == DRAIN) && !lat_done) begin
      lat_cnt <= lat_cnt + LAT_ONE;
    end else begin
      lat_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Job bookkeeping: remaining pair count and the PE baseline
  // ---------------------------------------------------------------------------
  // Bubbles (RUN with an empty FIFO) leave remaining untouched, so a job always
  // issues exactly i_len pairs no matter how the operands trickle in.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      remaining <= '0;
      base      <= '0;
    end else if (start_job) begin
      remaining <= i_len;
      base      <= i_pe_output;
    end else if (pop) begin
      remaining <= remaining - LEN_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand registers to the PE: the popped pair, or zeros
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_activation <= '0;
      o_weight     <= '0;
    end else if (pop) begin
      o_activation <= fifo_activation;
      o_weight     <= fifo_weight;
    end else begin
      o_activation <= '0;
      o_weight     <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Result register
  // ---------------------------------------------------------------------------
  // On the last DRAIN cycle the final pair has just reached i_pe_output. The
  // modular subtraction is exact even when the accumulator wrapped during the
  // job, since the dot product itself is only kept modulo 2^RW.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_result <= '0;
    end else if (start_job && (i_len == '0)) begin
      o_result <= '0;
    end else if ((state == DRAIN) && lat_done) begin
      o_result <= i_pe_output - base;
    end
  end

endmodule
